// File: rtl/apu_bridge_pkg.sv
// Shared types and helpers for the serial register-write bridge.
package apu_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Set in address bytes, clear in data bytes.
    localparam int unsigned ADDR_FLAG = 7;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int unsigned addr_width(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchroniser, bit timer and framing FSM with break recovery.
module uart_rx
    import apu_bridge_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 186
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) state_d = START;
            end
            START: begin
                if (cnt_q == HalfBit) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A start bit that is high again at mid-bit is a glitch.
                    state_d = rx_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_sync_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/apu_reg_bridge.sv
// Serial register-write bridge: pairs data/address bytes into register file writes.
// Optional stale-data timeout enabled by defining BRIDGE_TIMEOUT_EN.
module apu_reg_bridge
    import apu_bridge_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 1789773,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx,
    output logic [NUM_REGS*8-1:0]            reg_file,
    output logic                             wr_stb,
    output logic [addr_width(NUM_REGS)-1:0]  wr_addr,
    output logic [7:0]                       wr_data,
    output logic                             frame_err,
    output logic [7:0]                       err_count
);

    localparam int unsigned Cpb   = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned AddrW = addr_width(NUM_REGS);

    if (NUM_REGS < 1 || NUM_REGS > 64 || TIMEOUT_BITS == 0 || Cpb < 2) begin : g_bad_params
        $error("apu_reg_bridge: unsupported parameter combination");
    end

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT(Cpb)
    ) u_rx (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .byte_o      (rx_byte),
        .byte_valid_o(byte_valid),
        .frame_err_o (rx_frame_err)
    );

    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic [6:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             wr_stb_q, wr_stb_d;
    logic [AddrW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       err_q;
    logic             err_inc;
    logic [5:0]       idx;
    logic [7:0]       value;

    assign idx   = rx_byte[6:1];
    assign value = {rx_byte[0], hold_q};

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned TimeoutClks = TIMEOUT_BITS * Cpb;
    localparam int unsigned IdleW       = $clog2(TimeoutClks + 1);

    logic [IdleW-1:0] idle_q;
    logic             idle_hit;

    assign idle_hit = hold_valid_q && (idle_q == IdleW'(TimeoutClks));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else if (byte_valid || rx_frame_err || !hold_valid_q || idle_hit) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + 1'b1;
        end
    end
`endif

    always_comb begin
        regs_d       = regs_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        wr_stb_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
`ifdef BRIDGE_TIMEOUT_EN
        // Evaluated first so a byte arriving on the timeout cycle overrides it.
        if (idle_hit) hold_valid_d = 1'b0;
`endif
        if (byte_valid) begin
            if (!rx_byte[ADDR_FLAG]) begin
                hold_d       = rx_byte[6:0];
                hold_valid_d = 1'b1;
            end else begin
                if (hold_valid_q && (32'(idx) < NUM_REGS)) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (idx == 6'(i)) regs_d[i] = value;
                    end
                    wr_stb_d  = 1'b1;
                    wr_addr_d = idx[AddrW-1:0];
                    wr_data_d = value;
                end
                hold_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            wr_stb_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            regs_q       <= regs_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            wr_stb_q     <= wr_stb_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Count is shown already incremented while frame_err is high, so both change together.
    assign err_inc = rx_frame_err && (err_q != 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (err_inc) begin
            err_q <= err_q + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_file[8*g +: 8] = regs_q[g];
    end

    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = rx_frame_err;
    assign err_count = err_q + {7'd0, err_inc};

endmodule

// File: doc/apu_reg_bridge.md
# apu_reg_bridge

Serial register-write bridge for the audio core. Receives 8N1 UART bytes on one pin, pairs each 7-bit data byte with the address byte that follows it, and writes the 8-bit result into a parametrised register file. The register file drives the sound channels (square 1/2, triangle, noise), so the same serial stream format feeds one to many channels. Compared with a fixed four-channel decoder, this block adds a parametrised depth, a write strobe, framing-error accounting and a stale-data timeout.

## Interface
Parameters:
- CLK_HZ, 1789773: system clock frequency in Hz.
- BAUD, 9600: serial bit rate.
- NUM_REGS, 16: register count, 1..64.
- TIMEOUT_BITS, 40: idle bit-times before a held data byte is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle level is high.
- reg_file  out  NUM_REGS*8  flat register file; reg[i] = reg_file[8*i+7:8*i].
- wr_stb  out  1  one-cycle write pulse.
- wr_addr  out  $clog2(NUM_REGS) (minimum 1)  index of the last write.
- wr_data  out  8  data of the last write.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- err_count  out  8  framing-error count, saturates at 255.

## Operation
- CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, which is 186 at the defaults.
- rx passes through a 2-FF synchroniser before any logic uses it.
- Receiver FSM:
  - IDLE: a falling edge on the synchronised rx moves to START.
  - START: sample at CLKS_PER_BIT/2. If rx is high, treat it as a false start and return to IDLE. Otherwise go to DATA.
  - DATA: take 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - STOP: sample once. High pulses byte_valid and returns to IDLE. Low discards the byte, pulses frame_err, increments err_count and goes to BREAK.
  - BREAK: wait for rx high, then return to IDLE.
- Byte decoding uses a hold register hold[6:0] with a hold_valid flag.
- Data byte (bit7 = 0):
  - hold ← byte[6:0] and hold_valid ← 1.
  - A second data byte before an address byte overwrites the first.
- Address byte (bit7 = 1):
  - idx = byte[6:1] and d7 = byte[0].
  - If hold_valid is set and idx < NUM_REGS: reg[idx] ← {d7, hold}, wr_stb ← 1, wr_addr ← idx, wr_data ← value.
  - If hold_valid is clear, this is an orphan address. Ignore it and leave every register unchanged.
  - If idx ≥ NUM_REGS, make no write.
  - hold_valid ← 0 in all address cases.
- A framing error does not disturb hold or hold_valid.

## Timing
- Reset values:
  - Outputs: reg_file all 0, wr_stb 0, wr_addr 0, wr_data 0, frame_err 0, err_count 0.
  - Internal state: FSM in IDLE, hold_valid 0, synchroniser flops 1.
- Reset is asynchronous and may assert at any time, including mid-frame. On release the block waits for a fresh falling edge before accepting a byte.
- byte_valid rises 1 cycle after the stop-bit sample.
- reg_file, wr_stb, wr_addr and wr_data update on the clock edge after byte_valid, so the write appears 2 cycles after the stop-bit sample.
- Latency from the rx falling edge to wr_stb is 2 synchroniser cycles + 9.5 × CLKS_PER_BIT + 2 cycles.
- wr_stb is exactly 1 cycle wide. Back-to-back bytes can produce at most one write per frame.
- frame_err rises 1 cycle after the stop sample. err_count updates on the same edge and holds at 255.

## Configuration
- BRIDGE_TIMEOUT_EN is defined:
  - An idle counter clears on every byte_valid and on every frame_err. It counts only while hold_valid = 1.
  - When the counter reaches TIMEOUT_BITS × CLKS_PER_BIT, hold_valid ← 0.
  - If a byte_valid lands in the same cycle as the timeout, the byte wins: the counter clears and hold_valid is not cleared.
- BRIDGE_TIMEOUT_EN is not defined: there is no counter, and a held data byte stays until an address byte or reset.

## Structure
- Package apu_bridge_pkg holds:
  - The receiver state enum {IDLE, START, DATA, STOP, BREAK}.
  - Constant ADDR_FLAG = bit 7.
  - Function clks_per_bit(CLK_HZ, BAUD).
- Sub-module uart_rx contains the synchroniser, the bit timer and the FSM. It outputs byte, byte_valid and frame_err.
- The top level holds the hold/decode logic, the register file, the error counter and the optional timeout.

## Test plan
All scenarios use default parameters and 9600-baud frames with two stop bits.
1. Send 0x27, 0x83 → one wr_stb with wr_addr = 1, wr_data = 0xA7; reg[1] = 0xA7; all other registers stay 0.
2. Send 0x7C, 0x84, then 0x09, 0x86 → reg[2] = 0x7C and reg[3] = 0x09, with exactly two wr_stb pulses.
3. Send a lone 0x85, then 0x11, 0x10, 0x81 → the 0x85 produces no write; reg[0] = 0x90 because the second data byte overwrote the first.
4. Send 0x55 with its stop bit low, hold rx low 3 bit-times, then 0x02, 0x81 → frame_err pulses once, err_count = 1, then reg[0] = 0x82.
5. Send 0x30, idle 50 bit-times, then 0x81 → with BRIDGE_TIMEOUT_EN there is no write; without it reg[0] = 0xB0.
6. Two cases:
   - Send 0x10, 0xA0 (idx 16 with NUM_REGS = 16) → no write and hold_valid clears.
   - Assert rst during the DATA bits of a frame, release it, then send 0x08, 0x82 → reg_file is cleared by the reset and reg[1] = 0x08 afterwards.
